// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: ball-engine and score/video signals of the match sequencer (pause exists only with PONG_PAUSE_EN)
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic [9:0] ballx;
  logic [9:0] bally;
`ifdef PONG_PAUSE_EN
  logic       pause;
`endif
  logic       ball_hold;
  logic       ball_run;
  logic       serve_left;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       winner_l;
  logic [2:0] state_dbg;
  modport master (
`ifdef PONG_PAUSE_EN
    output pause,
`endif
    output frame_tick, start, ballx, bally,
    input  ball_hold, ball_run, serve_left, score_l, score_r, game_over, winner_l, state_dbg
  );
  modport slave (
`ifdef PONG_PAUSE_EN
    input  pause,
`endif
    input  frame_tick, start, ballx, bally,
    output ball_hold, ball_run, serve_left, score_l, score_r, game_over, winner_l, state_dbg
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong match sequencer (serve hold, miss detection, scores, winner); PONG_PAUSE_EN adds a pause toggle in PLAY
module pong_game_ctrl #(
  parameter int         WIN_SCORE    = 11,
  parameter int         SERVE_FRAMES = 60,
  parameter logic [9:0] LEFT_EDGE    = 10'd8,
  parameter logic [9:0] RIGHT_EDGE   = 10'd631
) (
  input logic clk,
  input logic rst,
  pong_game_ctrl_if.slave bus
);
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORED, OVER} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    score_l, score_l_n, score_r, score_r_n;
  logic          serve_left, serve_left_n, winner_l, winner_l_n, paused, paused_n;
  logic          unused_bally;
  assign unused_bally = ^bus.bally;
  // state and match registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      score_l    <= '0;
      score_r    <= '0;
      serve_left <= 1'b0;
      winner_l   <= 1'b0;
      paused     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      score_l    <= score_l_n;
      score_r    <= score_r_n;
      serve_left <= serve_left_n;
      winner_l   <= winner_l_n;
      paused     <= paused_n;
    end
  end
  // next-state, serve countdown, miss scoring and winner decision
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    score_l_n    = score_l;
    score_r_n    = score_r;
    serve_left_n = serve_left;
    winner_l_n   = winner_l;
    paused_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        score_l_n = '0;
        score_r_n = '0;
        if (bus.start) state_n = SERVE;
      end
      SERVE: if (bus.frame_tick) begin
        state_n = (cnt == CW'(SERVE_FRAMES - 1)) ? PLAY : SERVE;
        cnt_n   = (cnt == CW'(SERVE_FRAMES - 1)) ? '0 : cnt + 1'b1;
      end
      PLAY: begin
`ifdef PONG_PAUSE_EN
        paused_n = paused ^ bus.pause;
`endif
        if (bus.frame_tick && !paused) begin
          if (bus.ballx <= LEFT_EDGE) begin
            score_r_n    = score_r + 4'd1;
            serve_left_n = 1'b1;
            state_n      = SCORED;
          end else if (bus.ballx >= RIGHT_EDGE) begin
            score_l_n    = score_l + 4'd1;
            serve_left_n = 1'b0;
            state_n      = SCORED;
          end
        end
      end
      SCORED: begin
        state_n    = (score_l == 4'(WIN_SCORE) || score_r == 4'(WIN_SCORE)) ? OVER : SERVE;
        winner_l_n = score_l == 4'(WIN_SCORE);
      end
      OVER: if (bus.start) begin
        state_n    = SERVE;
        cnt_n      = '0;
        score_l_n  = '0;
        score_r_n  = '0;
        winner_l_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    paused_n = paused_n && state_n == PLAY;
  end
  assign bus.ball_hold  = state != PLAY;
  assign bus.ball_run   = state == PLAY && !paused;
  assign bus.serve_left = serve_left;
  assign bus.score_l    = score_l;
  assign bus.score_r    = score_r;
  assign bus.game_over  = state == OVER;
  assign bus.winner_l   = winner_l;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scoreboard bench for pong_game_ctrl (WIN_SCORE=3, SERVE_FRAMES=4)
module tb_pong_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  typedef struct {string n; logic [15:0] v;} exp_t;
  exp_t q[$];
  pong_game_ctrl_if bus();
  pong_game_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] e(input logic [2:0] st, input logic hold, input logic run,
      input logic sl, input logic [3:0] l, input logic [3:0] r, input logic go, input logic wl);
    return {st, hold, run, sl, l, r, go, wl};
  endfunction
  // monitor: compare the outputs produced by the last edge against the queued expectation
  always @(negedge clk) if (q.size() > 0) begin
    exp_t it;
    logic [15:0] act;
    it = q.pop_front();
    act = {bus.state_dbg, bus.ball_hold, bus.ball_run, bus.serve_left, bus.score_l, bus.score_r, bus.game_over, bus.winner_l};
    tests++;
    if (act !== it.v) begin
      fails++;
      $display("FAIL %s: got st=%0d hold=%b run=%b sl=%b l=%0d r=%0d go=%b wl=%b, want st=%0d hold=%b run=%b sl=%b l=%0d r=%0d go=%b wl=%b",
        it.n, act[15:13], act[12], act[11], act[10], act[9:6], act[5:2], act[1], act[0],
        it.v[15:13], it.v[12], it.v[11], it.v[10], it.v[9:6], it.v[5:2], it.v[1], it.v[0]);
    end
  end
  task automatic cyc(input logic r, input logic ft, input logic st, input logic p, input logic [9:0] x,
      input logic chk, input string n, input logic [15:0] v);
    exp_t it;
    @(negedge clk);
    rst = r;
    bus.frame_tick = ft;
    bus.start = st;
    bus.ballx = x;
`ifdef PONG_PAUSE_EN
    bus.pause = p;
`endif
    @(posedge clk);
    #1;
    if (chk) begin
      it.n = n;
      it.v = v;
      q.push_back(it);
    end
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
`ifdef PONG_PAUSE_EN
    bus.pause = 1'b0;
`else
    if (p) $display("pause unused");
`endif
  endtask
  task automatic serve4(input string n, input logic sl, input logic [3:0] l, input logic [3:0] r, input logic [9:0] x);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, x, 1, n, e(1, 1, 0, sl, l, r, 0, 0));
    cyc(0, 1, 0, 0, x, 1, {n, "_play"}, e(2, 0, 1, sl, l, r, 0, 0));
  endtask
  initial begin
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.ballx = 10'd320;
    bus.bally = 10'd240;
`ifdef PONG_PAUSE_EN
    bus.pause = 1'b0;
`endif
    cyc(1, 1, 1, 0, 320, 1, "rst1", e(0, 1, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 320, 1, "rst2", e(0, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 320, 1, "idle", e(0, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 1, 0, 320, 1, "start", e(1, 1, 0, 0, 0, 0, 0, 0));
    serve4("serve1", 0, 0, 0, 320);
    cyc(0, 0, 0, 0, 700, 1, "no_tick", e(2, 0, 1, 0, 0, 0, 0, 0));
    cyc(0, 0, 1, 0, 700, 1, "start_in_play", e(2, 0, 1, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 9, 1, "x9", e(2, 0, 1, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 630, 1, "x630", e(2, 0, 1, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 8, 1, "x8_scored", e(3, 1, 0, 1, 0, 1, 0, 0));
    cyc(0, 0, 1, 0, 8, 1, "after_score", e(1, 1, 0, 1, 0, 1, 0, 0));
    serve4("serve2", 1, 0, 1, 635);
    cyc(0, 1, 0, 0, 635, 1, "lmiss1", e(3, 1, 0, 0, 1, 1, 0, 0));
    cyc(0, 0, 0, 0, 635, 1, "lmiss1_srv", e(1, 1, 0, 0, 1, 1, 0, 0));
    serve4("serve3", 0, 1, 1, 635);
    cyc(0, 1, 0, 0, 631, 1, "lmiss2", e(3, 1, 0, 0, 2, 1, 0, 0));
    cyc(0, 0, 0, 0, 635, 1, "lmiss2_srv", e(1, 1, 0, 0, 2, 1, 0, 0));
    serve4("serve4", 0, 2, 1, 635);
    cyc(0, 1, 0, 0, 635, 1, "lmiss3", e(3, 1, 0, 0, 3, 1, 0, 0));
    cyc(0, 0, 0, 0, 635, 1, "over", e(4, 1, 0, 0, 3, 1, 1, 1));
    cyc(0, 1, 0, 0, 0, 1, "over_frozen", e(4, 1, 0, 0, 3, 1, 1, 1));
    cyc(0, 0, 1, 0, 320, 1, "restart", e(1, 1, 0, 0, 0, 0, 0, 0));
    serve4("serve5", 0, 0, 0, 320);
`ifdef PONG_PAUSE_EN
    cyc(0, 0, 0, 1, 320, 1, "pause_on", e(2, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 1, "paused_tick", e(2, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 1, 0, 1, "pause_off", e(2, 0, 1, 0, 0, 0, 0, 0));
`endif
    cyc(0, 1, 0, 0, 0, 1, "x0_scored", e(3, 1, 0, 1, 0, 1, 0, 0));
    cyc(0, 0, 0, 0, 0, 1, "x0_srv", e(1, 1, 0, 1, 0, 1, 0, 0));
    cyc(0, 1, 0, 0, 320, 1, "serve_cnt1", e(1, 1, 0, 1, 0, 1, 0, 0));
    cyc(1, 0, 0, 0, 320, 1, "rst_mid", e(0, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 1, 0, 320, 1, "start_tick", e(1, 1, 0, 0, 0, 0, 0, 0));
    serve4("serve6", 0, 0, 0, 320);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
